// File: rtl/split_constraint_checker_if.sv
// Handshake bundle for split_constraint_checker: transaction config, variable beat stream and verdict.
interface split_constraint_checker_if #(
  parameter int VAR_W = 16,
  parameter int SUM_W = 24,
  parameter int CNT_W = 6
);
  logic             start;
  logic [VAR_W-1:0] lo_bound;
  logic [VAR_W-1:0] hi_bound;
  logic [SUM_W-1:0] sum_limit;
  logic             in_valid;
  logic             in_ready;
  logic [VAR_W-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_sat;
  logic             out_err_len;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  modport master (
    output start, lo_bound, hi_bound, sum_limit, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sat, out_err_len, out_count, busy
  );

  modport slave (
    input  start, lo_bound, hi_bound, sum_limit, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sat, out_err_len, out_count, busy
  );
endinterface

// File: rtl/split_constraint_checker.sv
// Streams NUM_VARS solver variables, checks range and saturating sum, reports one verdict per transaction.
// Define SPLIT_TRIVIAL_EN to force every verdict to satisfied (trivially-true split constraint).
//
// state   | meaning
// IDLE    | waiting for start; config sampled on start
// COLLECT | accepting variable beats, accumulating sum/range/count
// REPORT  | verdict held on out_* until consumer handshake
module split_constraint_checker #(
  parameter int NUM_VARS = 35,
  parameter int VAR_W    = 16,
  parameter int SUM_W    = 24,
  parameter int CNT_W    = $clog2(NUM_VARS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  split_constraint_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VARS);
  localparam logic [SUM_W-1:0] SUM_MAX  = '1;

  state_t state, state_nxt;

  logic [VAR_W-1:0] lo_q, hi_q;
  logic [SUM_W-1:0] limit_q, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             range_ok_q, sat_q, err_q;

  logic             accept, final_beat, in_range;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SUM_W:0]   sum_wide;
  logic [SUM_W-1:0] sum_nxt;
  logic             range_nxt, err_nxt, sat_nxt;

  // Extra top bit of sum_wide catches overflow so the accumulator saturates instead of wrapping.
  always_comb begin
    accept     = (state == COLLECT) && bus.in_valid;
    cnt_nxt    = cnt_q + CNT_W'(1);
    sum_wide   = {1'b0, sum_q} + {{(SUM_W + 1 - VAR_W){1'b0}}, bus.in_data};
    sum_nxt    = sum_wide[SUM_W] ? SUM_MAX : sum_wide[SUM_W-1:0];
    in_range   = (bus.in_data >= lo_q) && (bus.in_data <= hi_q);
    range_nxt  = range_ok_q && in_range;
    final_beat = bus.in_last || (cnt_nxt == LAST_CNT);
    err_nxt    = (cnt_nxt != LAST_CNT) || !bus.in_last;
`ifdef SPLIT_TRIVIAL_EN
    sat_nxt    = 1'b1;
`else
    sat_nxt    = range_nxt && (sum_nxt <= limit_q) && !err_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = COLLECT;
      COLLECT: if (accept && final_beat) state_nxt = REPORT;
      REPORT:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q       <= '0;
      hi_q       <= '0;
      limit_q    <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      range_ok_q <= 1'b0;
      sat_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            lo_q       <= bus.lo_bound;
            hi_q       <= bus.hi_bound;
            limit_q    <= bus.sum_limit;
            sum_q      <= '0;
            cnt_q      <= '0;
            range_ok_q <= 1'b1;
            sat_q      <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        COLLECT: begin
          if (accept) begin
            sum_q      <= sum_nxt;
            cnt_q      <= cnt_nxt;
            range_ok_q <= range_nxt;
            if (final_beat) begin
              sat_q <= sat_nxt;
              err_q <= err_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == COLLECT);
  assign bus.out_valid   = (state == REPORT);
  assign bus.busy        = (state != IDLE);
  assign bus.out_sat     = sat_q;
  assign bus.out_err_len = err_q;
  assign bus.out_count   = cnt_q;

endmodule

// File: tb/tb_split_constraint_checker.sv
// Scoreboard bench for split_constraint_checker: dut_a (VAR_W=16, SUM_W=24) and dut_b (VAR_W=8, SUM_W=8), NUM_VARS=4.
module tb_split_constraint_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic sat;
    logic err;
    int   cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   beats [4];

  split_constraint_checker_if #(.VAR_W(16), .SUM_W(24), .CNT_W(3)) ifa();
  split_constraint_checker_if #(.VAR_W(8),  .SUM_W(8),  .CNT_W(3)) ifb();

  split_constraint_checker #(.NUM_VARS(4), .VAR_W(16), .SUM_W(24), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  split_constraint_checker #(.NUM_VARS(4), .VAR_W(8), .SUM_W(8), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic xs(input logic s);
`ifdef SPLIT_TRIVIAL_EN
    return 1'b1;
`else
    return s;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input bit sel, input bit st, input int lo, input int hi, input int lim);
    if (sel) begin
      ifb.start = st; ifb.lo_bound = lo[7:0]; ifb.hi_bound = hi[7:0]; ifb.sum_limit = lim[7:0];
    end else begin
      ifa.start = st; ifa.lo_bound = lo[15:0]; ifa.hi_bound = hi[15:0]; ifa.sum_limit = lim[23:0];
    end
  endtask

  task automatic drive_beat(input bit sel, input bit v, input int d, input bit last);
    if (sel) begin
      ifb.in_valid = v; ifb.in_data = d[7:0]; ifb.in_last = last;
    end else begin
      ifa.in_valid = v; ifa.in_data = d[15:0]; ifa.in_last = last;
    end
  endtask

  task automatic set_ready(input bit sel, input bit r);
    if (sel) ifb.out_ready = r;
    else     ifa.out_ready = r;
  endtask

  function automatic int rd_ready(input bit sel); return sel ? int'(ifb.in_ready)  : int'(ifa.in_ready);  endfunction
  function automatic int rd_valid(input bit sel); return sel ? int'(ifb.out_valid) : int'(ifa.out_valid); endfunction
  function automatic int rd_busy(input bit sel);  return sel ? int'(ifb.busy)      : int'(ifa.busy);      endfunction
  function automatic int rd_sat(input bit sel);   return sel ? int'(ifb.out_sat)   : int'(ifa.out_sat);   endfunction
  function automatic int rd_cnt(input bit sel);   return sel ? int'(ifb.out_count) : int'(ifa.out_count); endfunction

  task automatic wait_idle(input bit sel);
    int k = 0;
    while (rd_busy(sel) != 0 && k < 10) begin
      step();
      k++;
    end
    chk("idle_timeout", rd_busy(sel), 0);
  endtask

  // Issues one transaction using beats[0..n-1]; last_idx < 0 means in_last never asserted.
  task automatic run_txn(input bit sel, input int lo, input int hi, input int lim, input int n,
                         input int last_idx, input logic e_sat, input logic e_err, input int e_cnt,
                         input bit stall);
    exp_t e;
    e.sat = xs(e_sat);
    e.err = e_err;
    e.cnt = e_cnt;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
    set_ready(sel, !stall);
    drive_cfg(sel, 1'b1, lo, hi, lim);
    step();
    drive_cfg(sel, 1'b0, lo, hi, lim);
    for (int i = 0; i < n; i++) begin
      drive_beat(sel, 1'b1, beats[i], i == last_idx);
      chk("in_ready_collect", rd_ready(sel), 1);
      step();
    end
    drive_beat(sel, 1'b0, 0, 1'b0);
    chk("out_valid_latency", rd_valid(sel), 1);
    if (stall) begin
      for (int k = 0; k < 5; k++) begin
        step();
        chk("stall_out_valid", rd_valid(sel), 1);
        chk("stall_in_ready", rd_ready(sel), 0);
        chk("stall_out_sat", rd_sat(sel), e.sat);
        chk("stall_out_count", rd_cnt(sel), e_cnt);
      end
      drive_cfg(sel, 1'b1, lo, hi, lim);
      set_ready(sel, 1'b1);
      step();
      drive_cfg(sel, 1'b0, lo, hi, lim);
      chk("start_in_report_ignored", rd_busy(sel), 0);
      step();
      chk("stays_idle_after_report", rd_busy(sel), 0);
    end else begin
      wait_idle(sel);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ifa.out_valid && ifa.out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_verdict", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_out_sat", ifa.out_sat, e.sat);
        chk("a_out_err_len", ifa.out_err_len, e.err);
        chk("a_out_count", ifa.out_count, e.cnt);
      end
    end
    if (ifb.out_valid && ifb.out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_verdict", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_out_sat", ifb.out_sat, e.sat);
        chk("b_out_err_len", ifb.out_err_len, e.err);
        chk("b_out_count", ifb.out_count, e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive_cfg(0, 1'b0, 0, 0, 0);
    drive_cfg(1, 1'b0, 0, 0, 0);
    drive_beat(0, 1'b0, 0, 1'b0);
    drive_beat(1, 1'b0, 0, 1'b0);
    set_ready(0, 1'b1);
    set_ready(1, 1'b1);
    step();
    step();
    chk("rst_in_ready", ifa.in_ready, 0);
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_sat", ifa.out_sat, 0);
    chk("rst_out_err_len", ifa.out_err_len, 0);
    chk("rst_out_count", ifa.out_count, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_busy_b", ifb.busy, 0);
    rst = 1'b0;
    step();

    // in_valid while idle must not be accepted
    drive_beat(0, 1'b1, 99, 1'b1);
    step();
    chk("idle_in_ready", ifa.in_ready, 0);
    chk("idle_busy", ifa.busy, 0);
    drive_beat(0, 1'b0, 0, 1'b0);

    beats = '{3, 4, 5, 6};   run_txn(0, 2, 10, 30, 4, 3, 1'b1, 1'b0, 4, 1'b0);
    beats = '{3, 11, 5, 6};  run_txn(0, 2, 10, 30, 4, 3, 1'b0, 1'b0, 4, 1'b0);
    beats = '{3, 4, 5, 0};   run_txn(0, 2, 10, 10, 3, 2, 1'b0, 1'b1, 3, 1'b0);
    beats = '{1, 1, 1, 1};   run_txn(0, 0, 10, 100, 4, -1, 1'b0, 1'b1, 4, 1'b0);
    beats = '{5, 5, 5, 5};   run_txn(0, 10, 2, 100, 4, 3, 1'b0, 1'b0, 4, 1'b0);
    beats = '{3, 6, 3, 6};   run_txn(0, 3, 6, 18, 4, 3, 1'b1, 1'b0, 4, 1'b0);
    beats = '{3, 6, 3, 6};   run_txn(0, 3, 6, 17, 4, 3, 1'b0, 1'b0, 4, 1'b0);
    beats = '{5, 0, 0, 0};   run_txn(0, 0, 10, 100, 1, 0, 1'b0, 1'b1, 1, 1'b0);
    beats = '{255, 255, 255, 255}; run_txn(1, 0, 255, 255, 4, 3, 1'b1, 1'b0, 4, 1'b0);
    beats = '{255, 255, 255, 255}; run_txn(1, 0, 255, 254, 4, 3, 1'b0, 1'b0, 4, 1'b0);
    beats = '{3, 4, 5, 6};   run_txn(0, 2, 10, 30, 4, 3, 1'b1, 1'b0, 4, 1'b1);

    // reset in the middle of COLLECT aborts with no verdict
    drive_cfg(0, 1'b1, 2, 10, 30);
    step();
    drive_cfg(0, 1'b0, 2, 10, 30);
    drive_beat(0, 1'b1, 3, 1'b0);
    step();
    drive_beat(0, 1'b1, 4, 1'b0);
    step();
    drive_beat(0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_out_valid", ifa.out_valid, 0);
    chk("mid_rst_in_ready", ifa.in_ready, 0);
    chk("mid_rst_out_count", ifa.out_count, 0);
    step();
    chk("mid_rst_stays_idle", ifa.busy, 0);

    beats = '{3, 4, 5, 6};   run_txn(0, 2, 10, 30, 4, 3, 1'b1, 1'b0, 4, 1'b0);

    step();
    step();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/split_constraint_checker.md
Name: split_constraint_checker

Overview:
- Parametrised, sequential successor to the flat split_* constraint modules.
- Streams NUM_VARS solver variables one beat per cycle through a valid/ready handshake.
- Checks each variable against a configurable range and accumulates a saturating sum checked against a limit.
- Reports one satisfied/unsatisfied verdict per transaction; sits between the BDD solver's variable assignment stream and its result collector.

Parameters:
- NUM_VARS, 35, number of variables per transaction (>=1).
- VAR_W, 16, width of each variable beat (widest split variable, zero-extended).
- SUM_W, 24, accumulator width (>= VAR_W).
- CNT_W, $clog2(NUM_VARS+1), width of the beat counter and out_count.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse; begins a transaction when idle.
- lo_bound, input, VAR_W, unsigned lower range bound; sampled on the start cycle.
- hi_bound, input, VAR_W, unsigned upper range bound; sampled on the start cycle.
- sum_limit, input, SUM_W, maximum allowed sum; sampled on the start cycle.
- in_valid, input, 1, a variable beat is present.
- in_ready, output, 1, block accepts a beat.
- in_data, input, VAR_W, variable value.
- in_last, input, 1, marks the final beat of the transaction.
- out_valid, output, 1, verdict is valid.
- out_ready, input, 1, consumer accepts the verdict.
- out_sat, output, 1, constraint satisfied.
- out_err_len, output, 1, transaction length error.
- out_count, output, CNT_W, number of beats accepted.
- busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: in_ready=0, out_valid=0, out_sat=0, out_err_len=0, out_count=0, busy=0; FSM=IDLE; accumulator, counter and flags cleared. Reset mid-transaction aborts it with no verdict.
- FSM states: IDLE, COLLECT, REPORT.
- IDLE -> COLLECT: on start. Bounds and limit are registered; sum, count and range_ok (=1) are cleared.
- start is ignored outside IDLE.
- COLLECT: in_ready=1. A beat is accepted when in_valid && in_ready. On each accepted beat:
  - count += 1.
  - sum = min(sum + in_data, 2^SUM_W-1), saturating, never wraps.
  - range_ok &= (lo_bound <= in_data <= hi_bound), unsigned compare.
- COLLECT -> REPORT: on the accepted beat where in_last=1 or count reaches NUM_VARS, whichever comes first.
- Length error: err_len = (final count != NUM_VARS) OR (NUM_VARS-th beat accepted with in_last=0).
- Verdict: sat = range_ok && (sum <= sum_limit) && !err_len. Computed from the final beat included.
- Latency: out_valid rises in the cycle after the final beat handshake.
- REPORT: in_ready=0. out_valid, out_sat, out_err_len and out_count are held stable until out_valid && out_ready, then the FSM returns to IDLE on the next edge.
- Back-to-back: a start in the same cycle as the out handshake is ignored; it must arrive once the FSM is in IDLE.
- lo_bound > hi_bound: every beat fails the range check, so sat=0.
- in_valid while in IDLE or REPORT: no effect; beats are not accepted.

Optional Feature:
- Macro: SPLIT_TRIVIAL_EN.
- Defined: out_sat is forced to 1 for every verdict (trivially-true split constraint). The handshake, out_count and out_err_len behave unchanged; range and sum logic may be optimised away.
- Undefined: full range/sum/length evaluation as above.

Test Plan:
- NUM_VARS=4, lo=2, hi=10, limit=30; beats 3,4,5,6 with last on the 4th -> out_valid one cycle later, sat=1, err_len=0, count=4.
- Same config, beats 3,11,5,6 -> sat=0 (range fail), err_len=0, count=4.
- NUM_VARS=4, limit=10; beats 3,4,5 with last on the 3rd -> sat=0, err_len=1, count=3.
- SUM_W=8, VAR_W=8; beats 255,255,255,255 with limit=255 -> sum saturates at 255, sat=1; with limit=254 -> sat=0.
- out_ready held low 5 cycles -> verdict stable and in_ready=0 throughout; rst asserted mid-COLLECT -> next cycle busy=0, out_valid=0, and a new start works.
- SPLIT_TRIVIAL_EN defined, range-failing stream -> sat=1, count correct.
